// File: rtl/systolic_feeder.sv
// Operand store and diagonal-skew feeder for an N x N output-stationary systolic array.
// A start clears the array, streams A rows / B columns with skew, drains, then pulses done.
`timescale 1ns/1ps
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [$clog2(N)-1:0] wr_row,
    input  logic [$clog2(N)-1:0] wr_col,
    input  logic [DW-1:0]        wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 arr_clr,
    output logic                 feed_valid,
    output logic [N*DW-1:0]      a_row,
    output logic [N*DW-1:0]      b_col
);

    localparam int AW = $clog2(N);
    localparam int SW = $clog2(2 * N);
    localparam logic [SW-1:0] FEED_LAST  = SW'(2 * N - 2);
    localparam logic [SW-1:0] DRAIN_LAST = SW'(N - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     step_q, step_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              clr_q, clr_d;
    logic              fv_q, fv_d;
    logic [N*DW-1:0]   a_row_q, a_row_d;
    logic [N*DW-1:0]   b_col_q, b_col_d;
    logic [DW-1:0]     mem_a_q [N][N];
    logic [DW-1:0]     mem_a_d [N][N];
    logic [DW-1:0]     mem_b_q [N][N];
    logic [DW-1:0]     mem_b_d [N][N];
    logic [AW-1:0]     idx;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        clr_d   = 1'b0;
        fv_d    = 1'b0;
        mem_a_d = mem_a_q;
        mem_b_d = mem_b_q;
        idx     = '0;

        case (state_q)
            S_IDLE: begin
                if (wr_en) begin
                    if (wr_sel) mem_b_d[wr_row][wr_col] = wr_data;
                    else        mem_a_d[wr_row][wr_col] = wr_data;
                end
                if (start) begin
                    state_d = S_CLEAR;
                    busy_d  = 1'b1;
                    clr_d   = 1'b1;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                step_d  = '0;
                busy_d  = 1'b1;
                fv_d    = 1'b1;
            end
            S_FEED: begin
                busy_d = 1'b1;
                fv_d   = 1'b1;
                if (step_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                    step_d  = '0;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            S_DRAIN: begin
                busy_d = 1'b1;
                if (step_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    fv_d   = 1'b1;
                    step_d = step_q + SW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so the skew is computed for the step being entered.
        a_row_d = '0;
        b_col_d = '0;
        if (state_d == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                if (step_d >= SW'(i) && (step_d - SW'(i)) <= SW'(N - 1)) begin
                    idx = AW'(step_d - SW'(i));
                    a_row_d[i*DW +: DW] = mem_a_q[i][idx];
                    b_col_d[i*DW +: DW] = mem_b_q[idx][i];
                end
            end
        end
    end

    // NOTE: the operand stores are reset too, since a fresh part must feed zeros, not X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            fv_q    <= 1'b0;
            a_row_q <= '0;
            b_col_q <= '0;
            mem_a_q <= '{default: '0};
            mem_b_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clr_q   <= clr_d;
            fv_q    <= fv_d;
            a_row_q <= a_row_d;
            b_col_q <= b_col_d;
            mem_a_q <= mem_a_d;
            mem_b_q <= mem_b_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign arr_clr    = clr_q;
    assign feed_valid = fv_q;
    assign a_row      = a_row_q;
    assign b_col      = b_col_q;

endmodule
